// File: rtl/full_adder_data_flow_pkg.sv
// Shared constants for the ripple-carry full adder.
package full_adder_data_flow_pkg;

  localparam int DEFAULT_WIDTH = 1;

endpackage : full_adder_data_flow_pkg

// File: rtl/full_adder_data_flow_bit.sv
// One-bit full adder cell; chained by the top level to form a ripple-carry adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/full_adder_data_flow.sv
// Ripple-carry adder with an immediate dataflow result and a one-cycle registered copy.
module full_adder_data_flow
  import full_adder_data_flow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Carry_q,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    full_adder_bit u_bit (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign Sum   = s;
  assign Carry = c[WIDTH];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum_q     <= '0;
      Carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum_q   <= s;
        Carry_q <= c[WIDTH];
      end
    end
  end

endmodule : full_adder_data_flow

// File: tb/tb_full_adder_data_flow.sv
// Self-checking bench: directed literals at WIDTH=1/4, randomized WIDTH=8 against an arithmetic model.
module tb_full_adder_data_flow;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  // WIDTH=1 instance
  logic [0:0] a1 = '0, b1 = '0, s1, sq1;
  logic       cin1 = 1'b0, iv1 = 1'b0, c1, cq1, ov1;
  // WIDTH=4 instance
  logic [3:0] a4 = '0, b4 = '0, s4, sq4;
  logic       cin4 = 1'b0, iv4 = 1'b0, c4, cq4, ov4;
  // WIDTH=8 instance
  logic [7:0] a8 = '0, b8 = '0, s8, sq8;
  logic       cin8 = 1'b0, iv8 = 1'b0, c8, cq8, ov8;

  full_adder_data_flow #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
    .Sum(s1), .Carry(c1), .Sum_q(sq1), .Carry_q(cq1), .out_valid(ov1));

  full_adder_data_flow #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .in_valid(iv4),
    .Sum(s4), .Carry(c4), .Sum_q(sq4), .Carry_q(cq4), .out_valid(ov4));

  full_adder_data_flow #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(iv8),
    .Sum(s8), .Carry(c8), .Sum_q(sq8), .Carry_q(cq8), .out_valid(ov8));

  always begin
    #10;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the WIDTH=8 instance: the registered result is the
  // arithmetic sum of the last accepted operands, valid for one cycle.
  logic [8:0] m_res = '0;
  logic       m_valid = 1'b0;
  logic       rnd_active = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= iv8;
      if (iv8) m_res <= 9'(a8) + 9'(b8) + 9'(cin8);
    end
  end

  always @(negedge clk) begin
    if (rnd_active) begin
      logic [8:0] want;
      want = 9'(a8) + 9'(b8) + 9'(cin8);
      check("rnd_comb", {23'd0, c8, s8}, {23'd0, want});
      check("rnd_reg",  {23'd0, cq8, sq8}, {23'd0, m_res});
      check("rnd_valid", {31'd0, ov8}, {31'd0, m_valid});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sum_tbl;
    logic [7:0] car_tbl;
    logic [2:0] v;
    sum_tbl = 8'b1001_0110;
    car_tbl = 8'b1110_1000;

    // Reset held, clock stopped.
    #5;
    check("rst_sum_q",   {31'd0, sq1}, 32'd0);
    check("rst_carry_q", {31'd0, cq1}, 32'd0);
    check("rst_valid",   {31'd0, ov1}, 32'd0);
    check("rst_valid8",  {31'd0, ov8}, 32'd0);

    // Combinational path works while reset is asserted.
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    #5;
    check("indep_sum",     {31'd0, s1},  32'd0);
    check("indep_carry",   {31'd0, c1},  32'd1);
    check("indep_sum_q",   {31'd0, sq1}, 32'd0);
    check("indep_carry_q", {31'd0, cq1}, 32'd0);
    check("indep_valid",   {31'd0, ov1}, 32'd0);

    // Exhaustive WIDTH=1 truth table against hand-written literals.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      #5;
      check($sformatf("w1_sum_%0d", i),   {31'd0, s1}, {31'd0, sum_tbl[i]});
      check($sformatf("w1_carry_%0d", i), {31'd0, c1}, {31'd0, car_tbl[i]});
    end

    // WIDTH=4 wrap-around literals.
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; #5;
    check("w4_f_plus_1", {27'd0, c4, s4}, {27'd0, 1'b1, 4'h0});
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; #5;
    check("w4_f_f_1", {27'd0, c4, s4}, {27'd0, 1'b1, 4'hF});
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; #5;
    check("w4_zero", {27'd0, c4, s4}, 32'd0);

    // WIDTH=8 literal pinning the full-ripple case.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; #5;
    check("w8_ff_01_1", {23'd0, c8, s8}, {23'd0, 1'b1, 8'h01});
    a8 = '0; b8 = '0; cin8 = 1'b0;

    // Release reset and start the clock.
    rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);

    // Registered latency and hold on WIDTH=1.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    check("lat_sum_q",   {31'd0, sq1}, 32'd1);
    check("lat_carry_q", {31'd0, cq1}, 32'd1);
    check("lat_valid",   {31'd0, ov1}, 32'd1);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    check("hold_sum_q",   {31'd0, sq1}, 32'd1);
    check("hold_carry_q", {31'd0, cq1}, 32'd1);
    check("hold_valid",   {31'd0, ov1}, 32'd0);

    // Async reset between edges after a fresh 1/1 capture.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    check("pre_arst_valid", {31'd0, ov1}, 32'd1);
    iv1 = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_sum_q",   {31'd0, sq1}, 32'd0);
    check("arst_carry_q", {31'd0, cq1}, 32'd0);
    check("arst_valid",   {31'd0, ov1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized WIDTH=8 traffic; the compare process checks every cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      iv8  = ($urandom_range(3, 0) != 0);
      rnd_active = 1'b1;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    @(negedge clk); #1;
    rnd_active = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_full_adder_data_flow

// File: doc/full_adder_data_flow.md
# full_adder_data_flow

One-bit-slice full adder, widened by parameter to a ripple-carry adder. It provides a combinational (dataflow) sum/carry path and a one-cycle registered copy of the same result. The block is a leaf arithmetic primitive used by datapath blocks that need either an immediate sum or a clean registered result with a valid flag.

## Interface

Parameters:
- WIDTH, 1, operand and sum width in bits (≥1)

Ports:
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for the registered path only
- rst_n  input  1  asynchronous active-low reset for the registered path
- A  input  WIDTH  addend
- B  input  WIDTH  addend
- Cin  input  1  carry in to bit 0
- in_valid  input  1  capture strobe for the registered path
- Sum  output  WIDTH  combinational sum, (A+B+Cin) mod 2^WIDTH
- Carry  output  1  combinational carry out of MSB
- Sum_q  output  WIDTH  registered Sum
- Carry_q  output  1  registered Carry
- out_valid  output  1  Sum_q/Carry_q hold a result captured from a valid input

## Operation

- Bit cell i computes:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i])
  - c[0] = Cin
- Sum = s, Carry = c[WIDTH].
- Sum and Carry are pure continuous dataflow: no clock or reset dependency, and valid whenever inputs are stable.
- Arithmetic is unsigned and modulo 2^WIDTH. Carry is the (WIDTH+1)-th result bit, so {Carry,Sum} = A + B + Cin exactly, with no truncation.
- Registered path, on each rising clk edge:
  - If in_valid=1: Sum_q←Sum, Carry_q←Carry, out_valid←1.
  - If in_valid=0: Sum_q and Carry_q hold; out_valid←0.
- Reset (rst_n=0, asynchronous): Sum_q=0, Carry_q=0, out_valid=0, immediately and independent of clk. The combinational outputs are unaffected by reset.
- Reset deasserted mid-operation: the first capture occurs on the first rising edge with rst_n=1 and in_valid=1.
- X/Z on inputs propagates per standard Verilog operators. No sanitising.

## Timing

- Combinational path latency: 0 cycles, with a ripple delay of WIDTH cell stages. The bench samples at least 5 time units after any input change.
- Registered path latency: 1 cycle. A result presented with in_valid at edge n appears on Sum_q/Carry_q with out_valid=1 after edge n.
- out_valid is a single-cycle pulse per valid input. Back-to-back in_valid gives a continuous out_valid.
- No backpressure, so the block always accepts input.

## Structure

- Sub-module full_adder_bit: a one-bit cell (a, b, cin → s, cout), instantiated WIDTH times in a generate loop.
- Shared package: the default WIDTH constant only. No typedefs are needed.
- The top level contains the generate chain, the output assigns, and one always block with the async reset.

## Test plan

- Exhaustive at WIDTH=1: drive {A,B,Cin}=0..7, 5 time units apart → Sum/Carry = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- Combinational independence: hold rst_n=0 with clk stopped and apply A=1, B=0, Cin=1 → Sum=0, Carry=1. Sum_q=0, Carry_q=0, out_valid=0.
- Registered latency: A=1, B=1, Cin=1, in_valid=1 for one edge → after that edge Sum_q=1, Carry_q=1, out_valid=1. After the next edge with in_valid=0, Sum_q/Carry_q hold and out_valid=0.
- Async reset mid-operation: after a capture of 1/1, assert rst_n low between edges → Sum_q, Carry_q and out_valid go to 0 without a clock edge.
- Wrap-around at WIDTH=4: A=4'hF, B=4'h1, Cin=0 → Sum=4'h0, Carry=1. A=4'hF, B=4'hF, Cin=1 → Sum=4'hF, Carry=1. A=0, B=0, Cin=0 → 0/0.
- Random at WIDTH=8: 1000 vectors checked against {Carry,Sum} == A+B+Cin on both paths, with Sum_q checked one cycle later.
